// File: rtl/game_phase_sequencer.sv
// -----------------------------------------------------------------------------
// game_phase_sequencer
//
// Round sequencer for the symbol-counting game. It walks through the phases
// PRE -> GAME -> ANSWER -> POST once per round. Each phase is timed in whole
// seconds, derived from Clk100M. When ANSWER ends, the player's count is
// latched and judged against the game's count. A failed round ends in LOSE.
// Passing NUM_ROUNDS rounds ends in VICTORY. Both terminal states hold until
// start is asserted.
//
// Ports:
//   Clk100M            system clock
//   Rst_n              asynchronous active-low reset
//   start              debounced start/replay request, sampled every cycle
//   userCount[7:0]     player's count, sampled on the ANSWER->POST edge
//   gameCount[7:0]     real symbol count, sampled on the ANSWER->POST edge
//   pre/game/answer/post/lose/victory
//                      registered phase flags, at most one high at a time
//   secLeft[3:0]       seconds remaining in the current timed phase
//   round[3:0]         current round, 1-based; 0 while idle
//   postPage[1:0]      POST sub-screen index
//   countDiff[7:0]     latched |userCount - gameCount|
//   roundWin           latched countDiff <= TOL
// -----------------------------------------------------------------------------
module game_phase_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int PRE_SECS    = 3,
  parameter int GAME_SECS   = 10,
  parameter int ANSWER_SECS = 5,
  parameter int NUM_ROUNDS  = 5,
  parameter int TOL         = 0
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [7:0] userCount,
  input  logic [7:0] gameCount,
  output logic       pre,
  output logic       game,
  output logic       answer,
  output logic       post,
  output logic       lose,
  output logic       victory,
  output logic [3:0] secLeft,
  output logic [3:0] round,
  output logic [1:0] postPage,
  output logic [7:0] countDiff,
  output logic       roundWin
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_GAME, S_ANSWER, S_POST, S_LOSE, S_VICTORY
  } state_e;

  localparam logic [26:0] TICK_LAST  = 27'(TICK_DIV - 1);
  localparam logic [3:0]  PRE_W      = 4'(PRE_SECS);
  localparam logic [3:0]  GAME_W     = 4'(GAME_SECS);
  localparam logic [3:0]  ANSWER_W   = 4'(ANSWER_SECS);
  localparam logic [3:0]  ROUNDS_W   = 4'(NUM_ROUNDS);
  localparam logic [7:0]  TOL_W      = 8'(TOL);

  state_e      state_q, state_d;
  logic [26:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  sec_left_q, sec_left_d;
  logic [3:0]  round_q, round_d;
  logic [1:0]  post_page_q, post_page_d;
  logic [7:0]  count_diff_q, count_diff_d;
  logic        round_win_q, round_win_d;
  // Flag order: {pre, game, answer, post, lose, victory}
  logic [5:0]  flags_q, flags_d;

  logic        tick;
  logic        timed_phase;
  logic [7:0]  abs_diff;

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign abs_diff = (userCount >= gameCount) ? (userCount - gameCount)
                                             : (gameCount - userCount);

  always_comb begin
    // NOTE: every signal gets a default before the case; any path that skips
    // an assignment would otherwise infer a latch.
    state_d      = state_q;
    sec_left_d   = sec_left_q;
    round_d      = round_q;
    post_page_d  = post_page_q;
    count_diff_d = count_diff_q;
    round_win_d  = round_win_q;
    timed_phase  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PRE;
          round_d    = 4'd1;
          sec_left_d = PRE_W;
        end
      end

      S_PRE: begin
        timed_phase = 1'b1;
        if (tick) begin
          if (sec_left_q == 4'd1) begin
            state_d    = S_GAME;
            sec_left_d = GAME_W;
          end else begin
            sec_left_d = sec_left_q - 4'd1;
          end
        end
      end

      S_GAME: begin
        timed_phase = 1'b1;
        if (tick) begin
          if (sec_left_q == 4'd1) begin
            state_d    = S_ANSWER;
            sec_left_d = ANSWER_W;
          end else begin
            sec_left_d = sec_left_q - 4'd1;
          end
        end
      end

      S_ANSWER: begin
        timed_phase = 1'b1;
        if (tick) begin
          if (sec_left_q == 4'd1) begin
            // The counts are judged in the same cycle that ANSWER ends.
            state_d      = S_POST;
            sec_left_d   = 4'd0;
            post_page_d  = 2'd0;
            count_diff_d = abs_diff;
            round_win_d  = (abs_diff <= TOL_W);
          end else begin
            sec_left_d = sec_left_q - 4'd1;
          end
        end
      end

      S_POST: begin
        timed_phase = 1'b1;
        if (tick) begin
          if (post_page_q == 2'd3) begin
            post_page_d = 2'd0;
            if (!round_win_q) begin
              state_d = S_LOSE;
            end else if (round_q == ROUNDS_W) begin
              state_d = S_VICTORY;
            end else begin
              state_d    = S_PRE;
              round_d    = round_q + 4'd1;
              sec_left_d = PRE_W;
            end
          end else begin
            post_page_d = post_page_q + 2'd1;
          end
        end
      end

      S_LOSE, S_VICTORY: begin
        if (start) begin
          state_d      = S_IDLE;
          round_d      = 4'd0;
          count_diff_d = 8'd0;
          round_win_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The tick counter restarts on every state change, so each phase lasts
    // exactly N whole ticks. Outside the timed phases it is held at 0.
    if (!timed_phase || (state_d != state_q) || tick) begin
      tick_cnt_d = 27'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 27'd1;
    end

    // The flags are decoded from the next state, so they change on the same
    // edge as the state itself and come straight out of flops.
    flags_d = 6'b000000;
    unique case (state_d)
      S_PRE:     flags_d = 6'b100000;
      S_GAME:    flags_d = 6'b010000;
      S_ANSWER:  flags_d = 6'b001000;
      S_POST:    flags_d = 6'b000100;
      S_LOSE:    flags_d = 6'b000010;
      S_VICTORY: flags_d = 6'b000001;
      default:   flags_d = 6'b000000;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 27'd0;
      sec_left_q   <= 4'd0;
      round_q      <= 4'd0;
      post_page_q  <= 2'd0;
      count_diff_q <= 8'd0;
      round_win_q  <= 1'b0;
      flags_q      <= 6'b000000;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      sec_left_q   <= sec_left_d;
      round_q      <= round_d;
      post_page_q  <= post_page_d;
      count_diff_q <= count_diff_d;
      round_win_q  <= round_win_d;
      flags_q      <= flags_d;
    end
  end

  assign {pre, game, answer, post, lose, victory} = flags_q;
  assign secLeft   = sec_left_q;
  assign round     = round_q;
  assign postPage  = post_page_q;
  assign countDiff = count_diff_q;
  assign roundWin  = round_win_q;

endmodule
